// File: rtl/lc3b_regbank.sv
// rtl/lc3b_regbank.sv - LC-3b R0-R7 register bank with N/Z/P codes and busy scoreboard
// Define REGBANK_BYPASS_EN to forward the write value onto data[wr_addr] in the write cycle.
module lc3b_regbank #(
  parameter int         WIDTH    = 16,
  parameter logic [2:0] CC_RESET = 3'b010
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [2:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_byte,
  input  logic             wr_setcc,
  input  logic             mark_en,
  input  logic [2:0]       mark_addr,
  output logic [WIDTH-1:0] data0,
  output logic [WIDTH-1:0] data1,
  output logic [WIDTH-1:0] data2,
  output logic [WIDTH-1:0] data3,
  output logic [WIDTH-1:0] data4,
  output logic [WIDTH-1:0] data5,
  output logic [WIDTH-1:0] data6,
  output logic [WIDTH-1:0] data7,
  output logic             cc_n,
  output logic             cc_z,
  output logic             cc_p,
  output logic [7:0]       busy
);

  logic [WIDTH-1:0] regs_q [8];
  logic [WIDTH-1:0] rd     [8];
  logic [WIDTH-1:0] sv;
  logic [2:0]       cc_q, cc_d;
  logic [7:0]       busy_q, busy_d;
  logic             sv_n, sv_z;

  assign sv   = wr_byte ? {{(WIDTH-8){wr_data[7]}}, wr_data[7:0]} : wr_data;
  assign sv_n = sv[WIDTH-1];
  assign sv_z = (sv == '0);

  always_comb begin
    cc_d = cc_q;
    if (wr_en && wr_setcc) cc_d = {sv_n, sv_z, !sv_n && !sv_z};
  end

  // Mark is applied after clear so a newly issued producer wins on the same register.
  always_comb begin
    busy_d = busy_q;
    if (wr_en)   busy_d[wr_addr]   = 1'b0;
    if (mark_en) busy_d[mark_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
      cc_q   <= CC_RESET;
      busy_q <= 8'h00;
    end else begin
      if (wr_en) regs_q[wr_addr] <= sv;
      cc_q   <= cc_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      rd[i] = regs_q[i];
`ifdef REGBANK_BYPASS_EN
      if (wr_en && (wr_addr == 3'(i))) rd[i] = sv;
`endif
    end
  end

  assign data0 = rd[0];
  assign data1 = rd[1];
  assign data2 = rd[2];
  assign data3 = rd[3];
  assign data4 = rd[4];
  assign data5 = rd[5];
  assign data6 = rd[6];
  assign data7 = rd[7];

  assign {cc_n, cc_z, cc_p} = cc_q;
  assign busy               = busy_q;

endmodule

// File: tb/tb_lc3b_regbank.sv
// tb/tb_lc3b_regbank.sv - directed and random checks of lc3b_regbank against a bench model
module tb_lc3b_regbank;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_en, wr_byte, wr_setcc, mark_en;
  logic [2:0]  wr_addr, mark_addr;
  logic [15:0] wr_data;
  logic [15:0] d0, d1, d2, d3, d4, d5, d6, d7;
  logic        cc_n, cc_z, cc_p;
  logic [7:0]  busy;

  int nchecks = 0;
  int nerr    = 0;

  int        m_reg  [8];
  int        m_busy [8];
  int        m_cc;
  bit        cmp_en = 1'b0;

  lc3b_regbank dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_byte(wr_byte), .wr_setcc(wr_setcc), .mark_en(mark_en), .mark_addr(mark_addr),
    .data0(d0), .data1(d1), .data2(d2), .data3(d3), .data4(d4), .data5(d5), .data6(d6), .data7(d7),
    .cc_n(cc_n), .cc_z(cc_z), .cc_p(cc_p), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] dsel(input int i);
    case (i)
      0: return d0;
      1: return d1;
      2: return d2;
      3: return d3;
      4: return d4;
      5: return d5;
      6: return d6;
      default: return d7;
    endcase
  endfunction

  function automatic int stored(input logic [15:0] wd, input logic wb);
    int v;
    if (!wb) return int'(wd);
    v = int'(wd) % 256;
    if (v >= 128) v = v + 65536 - 256;
    return v;
  endfunction

  // N=4, Z=2, P=1 in {N,Z,P} order
  function automatic int cc_of(input int v);
    if (v >= 32768) return 4;
    if (v == 0) return 2;
    return 1;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) begin
        m_reg[i]  = 0;
        m_busy[i] = 0;
      end
      m_cc = 2;
    end else begin
      if (wr_en) begin
        m_reg[wr_addr]  = stored(wr_data, wr_byte);
        m_busy[wr_addr] = 0;
        if (wr_setcc) m_cc = cc_of(m_reg[wr_addr]);
      end
      if (mark_en) m_busy[mark_addr] = 1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      int bexp;
      int dexp;
      bexp = 0;
      for (int i = 0; i < 8; i++) begin
        dexp = m_reg[i];
`ifdef REGBANK_BYPASS_EN
        if (reset_n && wr_en && int'(wr_addr) == i) dexp = stored(wr_data, wr_byte);
`endif
        chk($sformatf("model_data%0d", i), dsel(i), 16'(dexp));
        bexp = bexp + m_busy[i] * (1 << i);
      end
      chk("model_cc", {13'd0, cc_n, cc_z, cc_p}, 16'(m_cc));
      chk("model_busy", {8'd0, busy}, 16'(bexp));
    end
  end

  task automatic idle();
    wr_en = 0; wr_addr = 0; wr_data = 0; wr_byte = 0; wr_setcc = 0; mark_en = 0; mark_addr = 0;
  endtask

  task automatic step(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                      input logic wb, input logic sc, input logic me, input logic [2:0] ma);
    wr_en = we; wr_addr = wa; wr_data = wd; wr_byte = wb; wr_setcc = sc;
    mark_en = me; mark_addr = ma;
    @(posedge clk);
    #1;
    idle();
  endtask

  function automatic logic [15:0] ccv();
    return {13'd0, cc_n, cc_z, cc_p};
  endfunction

  initial begin
    idle();
    reset_n = 0;
    cmp_en  = 1;
    repeat (2) @(posedge clk);
    #3 reset_n = 1;

    step(1, 3'd6, 16'h5555, 0, 1, 1, 3'd2);
    chk("pre_reset_data6", d6, 16'h5555);
    chk("pre_reset_busy", {8'd0, busy}, 16'h0004);
    #2 reset_n = 0;
    #1;
    for (int i = 0; i < 8; i++) chk($sformatf("reset_data%0d", i), dsel(i), 16'h0000);
    chk("reset_cc", ccv(), 16'h0002);
    chk("reset_busy", {8'd0, busy}, 16'h0000);
    #3 reset_n = 1;

    step(1, 3'd3, 16'h1234, 0, 0, 0, 3'd0);
    chk("write_r3", d3, 16'h1234);
    #2 reset_n = 0;
    #1 chk("async_reset_r3", d3, 16'h0000);
    #3 reset_n = 1;

    step(1, 3'd5, 16'h8001, 0, 1, 0, 3'd0);
    chk("r5_8001", d5, 16'h8001);
    chk("cc_neg", ccv(), 16'h0004);
    step(1, 3'd5, 16'h0000, 0, 1, 0, 3'd0);
    chk("r5_zero", d5, 16'h0000);
    chk("cc_zero", ccv(), 16'h0002);
    step(1, 3'd5, 16'h0001, 0, 0, 0, 3'd0);
    chk("r5_one", d5, 16'h0001);
    chk("cc_nosetcc", ccv(), 16'h0002);

    step(1, 3'd2, 16'hAB80, 1, 1, 0, 3'd0);
    chk("byte_neg", d2, 16'hFF80);
    chk("byte_neg_cc", ccv(), 16'h0004);
    step(1, 3'd2, 16'h127F, 1, 1, 0, 3'd0);
    chk("byte_pos", d2, 16'h007F);
    chk("byte_pos_cc", ccv(), 16'h0001);

    step(0, 3'd0, 16'h0000, 0, 0, 1, 3'd1);
    chk("mark_r1", {8'd0, busy}, 16'h0002);
    step(1, 3'd1, 16'h0042, 0, 0, 1, 3'd4);
    chk("mark_r4_write_r1", {8'd0, busy}, 16'h0010);
    step(1, 3'd4, 16'h0043, 0, 0, 1, 3'd4);
    chk("mark_wins", {8'd0, busy}, 16'h0010);
    step(1, 3'd6, 16'h0044, 0, 0, 0, 3'd0);
    chk("write_idle_reg", {8'd0, busy}, 16'h0010);

    step(1, 3'd7, 16'h1111, 0, 0, 0, 3'd0);
    wr_en = 1; wr_addr = 3'd7; wr_data = 16'hBEEF;
    #1;
`ifdef REGBANK_BYPASS_EN
    chk("bypass_same_cycle", d7, 16'hBEEF);
`else
    chk("no_bypass_old", d7, 16'h1111);
`endif
    @(posedge clk);
    #1;
    idle();
    chk("r7_committed", d7, 16'hBEEF);

    for (int k = 0; k < 20; k++) begin
      step(0, 3'($urandom), 16'($urandom), 1'($urandom), (k % 2 == 0) ? 1'b1 : 1'($urandom), 0, 3'd0);
    end
    chk("hold_r2", d2, 16'h007F);
    chk("hold_r5", d5, 16'h0001);
    chk("hold_r7", d7, 16'hBEEF);
    chk("hold_cc", ccv(), 16'h0001);
    chk("hold_busy", {8'd0, busy}, 16'h0010);

    for (int k = 0; k < 40; k++) begin
      wr_en = 1'($urandom); wr_addr = 3'($urandom); wr_data = 16'($urandom);
      wr_byte = 1'($urandom); wr_setcc = 1'($urandom);
      mark_en = 1'($urandom); mark_addr = 3'($urandom);
      @(posedge clk);
      #1;
    end
    idle();
    repeat (2) @(posedge clk);
    #1;
    cmp_en = 0;

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
